instruction_cache: RTL and testbench

//  Direct-mapped, read-only instruction cache directly upstream of the single-cycle cpu.

---
 rtl/instruction_cache.sv | 135 +++++++++++++
 tb/tb_instruction_cache.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache for a single-cycle CPU.
// Hits answer combinationally from PC; misses stall the CPU and refill one 128-bit block.
module instruction_cache #(
    parameter int ADDR_BITS   = 10,
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 4,
    parameter int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [31:0]                    PC,
    output logic [31:0]                    INSTRUCTION,
    output logic                           BUSYWAIT,
    output logic                           MEM_READ,
    output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
    input  logic [127:0]                   MEM_READDATA,
    input  logic                           MEM_BUSYWAIT
);

    localparam int BLK_BITS   = TAG_BITS + INDEX_BITS;
    localparam int NUM_BLOCKS = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [BLK_BITS-1:0]   req_addr_q, req_addr_d;
    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
    logic [TAG_BITS-1:0]   tag_d  [NUM_BLOCKS];
    logic [127:0]          data_q [NUM_BLOCKS];
    logic [127:0]          data_d [NUM_BLOCKS];

    logic [TAG_BITS-1:0]   pc_tag_s;
    logic [INDEX_BITS-1:0] pc_index_s;
    logic [1:0]            pc_word_s;
    logic [INDEX_BITS-1:0] req_index_s;
    logic [TAG_BITS-1:0]   req_tag_s;
    logic                  hit_s;
    logic [127:0]          line_s;
    logic [31:0]           word_s;
    logic                  busywait_s;
    logic                  mem_read_s;
    logic [BLK_BITS-1:0]   mem_address_s;
    logic                  unused_s;

    assign pc_tag_s    = PC[ADDR_BITS-1 -: TAG_BITS];
    assign pc_index_s  = PC[OFFSET_BITS+INDEX_BITS-1 -: INDEX_BITS];
    assign pc_word_s   = PC[3:2];
    assign req_index_s = req_addr_q[INDEX_BITS-1:0];
    assign req_tag_s   = req_addr_q[BLK_BITS-1 -: TAG_BITS];
    assign unused_s    = ^{PC[31:ADDR_BITS], PC[1:0]};

    assign hit_s  = valid_q[pc_index_s] && (tag_q[pc_index_s] == pc_tag_s);
    assign line_s = data_q[pc_index_s];

    // Word select within the indexed block
    always_comb begin
        word_s = 32'd0;
        case (pc_word_s)
            2'd0:    word_s = line_s[31:0];
            2'd1:    word_s = line_s[63:32];
            2'd2:    word_s = line_s[95:64];
            2'd3:    word_s = line_s[127:96];
            default: word_s = 32'd0;
        endcase
    end

    // Refill controller: next state, array updates and handshake outputs
    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        valid_d       = valid_q;
        tag_d         = tag_q;
        data_d        = data_q;
        busywait_s    = 1'b0;
        mem_read_s    = 1'b0;
        mem_address_s = {BLK_BITS{1'b0}};
        case (state_q)
            S_IDLE: begin
                busywait_s = !hit_s;
                if (!hit_s) begin
                    req_addr_d = {pc_tag_s, pc_index_s};
                    state_d    = S_MEM_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MEM_READ: begin
                busywait_s    = 1'b1;
                mem_read_s    = 1'b1;
                mem_address_s = req_addr_q;
                // The fill targets the latched block, whatever PC shows now
                if (!MEM_BUSYWAIT) begin
                    data_d[req_index_s]  = MEM_READDATA;
                    tag_d[req_index_s]   = req_tag_s;
                    valid_d[req_index_s] = 1'b1;
                    state_d              = S_UPDATE;
                end else begin
                    state_d = S_MEM_READ;
                end
            end
            S_UPDATE: begin
                busywait_s = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and storage registers; reset clears only state and valid bits
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            valid_q <= {NUM_BLOCKS{1'b0}};
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
        end
    end

    assign BUSYWAIT    = !RESET && busywait_s;
    assign MEM_READ    = !RESET && mem_read_s;
    assign MEM_ADDRESS = RESET ? {BLK_BITS{1'b0}} : mem_address_s;
    assign INSTRUCTION = RESET ? 32'd0 : word_s;

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: a behavioural memory and a block-residency
// model predict instruction, stall length and memory requests; monitors compare.
module tb_instruction_cache;

    logic         CLK;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    instruction_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    typedef struct {
        logic [31:0] instr;
        int          stall;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [5:0]  addr_q[$];
    logic [31:0] words[256];
    int          resident[8];
    int          mem_lat;
    int          mem_cnt;
    int          busy_cnt;
    int          errors;
    int          checks;
    bit          pause;
    logic        mem_read_prev;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Instruction memory: ready on the mem_lat-th cycle of a request
    always @(posedge CLK) begin
        if (MEM_READ) mem_cnt <= mem_cnt + 1;
        else          mem_cnt <= 0;
    end

    always_comb begin
        MEM_BUSYWAIT = !(MEM_READ && (mem_cnt == mem_lat - 1));
        MEM_READDATA = 128'd0;
        for (int w = 0; w < 4; w++)
            MEM_READDATA[32*w +: 32] = words[int'(MEM_ADDRESS) * 4 + w];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion at %0t", name, $time);
        finish_run();
    endtask

    // Monitor: reset outputs, memory requests, and served fetches
    always @(negedge CLK) begin
        if (RESET) begin
            check("rst_busywait", {127'd0, BUSYWAIT}, 128'd0);
            check("rst_mem_read", {127'd0, MEM_READ}, 128'd0);
            check("rst_mem_address", {122'd0, MEM_ADDRESS}, 128'd0);
            check("rst_instruction", {96'd0, INSTRUCTION}, 128'd0);
            busy_cnt = 0;
        end else begin
            if (MEM_READ && !mem_read_prev) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_mem_read", {122'd0, MEM_ADDRESS}, 128'h1_0000);
                end else begin
                    check("mem_address", {122'd0, MEM_ADDRESS}, {122'd0, addr_q.pop_front()});
                end
            end
            if (!pause && exp_q.size() > 0) begin
                if (BUSYWAIT) begin
                    busy_cnt++;
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("instruction", {96'd0, INSTRUCTION}, {96'd0, e.instr});
                    check("stall_cycles", busy_cnt, e.stall);
                    busy_cnt = 0;
                end
            end
        end
        mem_read_prev = MEM_READ;
    end

    // Present one PC as the CPU would, predict the response, and hold until served
    task automatic present(input logic [31:0] pc, input bit release_rst);
        int   blk;
        int   idx;
        bit   hit;
        bit   done;
        exp_t e;
        @(posedge CLK);
        #1;
        blk     = int'(pc[9:4]);
        idx     = blk % 8;
        hit     = (resident[idx] == blk);
        e.instr = words[int'(pc[9:2])];
        e.stall = hit ? 0 : mem_lat + 2;
        e.pc    = pc;
        exp_q.push_back(e);
        if (!hit) begin
            addr_q.push_back(pc[9:4]);
            resident[idx] = blk;
        end
        PC = pc;
        if (release_rst) RESET = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            #1;
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout("fetch_served");
    endtask

    task automatic wait_mem_read();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (MEM_READ) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout("mem_read_seen");
    endtask

    initial begin
        logic [31:0] last_pc;
        logic [31:0] pc;
        bit          seen;
        errors        = 0;
        checks        = 0;
        pause         = 1'b0;
        busy_cnt      = 0;
        mem_read_prev = 1'b0;
        mem_lat       = 3;
        for (int i = 0; i < 256; i++) words[i] = $urandom;
        words[0] = 32'h0000_0001;
        words[1] = 32'h0000_0102;
        words[2] = 32'h0000_0203;
        words[3] = 32'h0000_0304;
        for (int i = 0; i < 8; i++) resident[i] = -1;
        RESET = 1'b1;
        PC    = 32'd0;
        repeat (3) @(posedge CLK);

        // Cold miss on block 0, then sequential hits in the same block
        mem_lat = 3;
        present(32'h000, 1'b1);
        present(32'h004, 1'b0);
        present(32'h008, 1'b0);
        present(32'h00C, 1'b0);

        // Conflict eviction on index 0 and back again
        mem_lat = 2;
        present(32'h080, 1'b0);
        present(32'h000, 1'b0);

        // Top of the address space, then aliasing above bit 9
        mem_lat = 1;
        present(32'h3FC, 1'b0);
        present(32'h400, 1'b0);

        // Reset in the middle of a fill
        pause = 1'b1;
        @(posedge CLK);
        #1;
        mem_lat = 4;
        addr_q.push_back(6'h05);
        PC = 32'h050;
        wait_mem_read();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        for (int i = 0; i < 8; i++) resident[i] = -1;
        pause = 1'b0;
        present(32'h000, 1'b1);
        present(32'h050, 1'b0);

        // PC change during a fill does not redirect it
        pause = 1'b1;
        @(posedge CLK);
        #1;
        mem_lat = 3;
        addr_q.push_back(6'h01);
        PC = 32'h010;
        wait_mem_read();
        @(posedge CLK);
        #1;
        addr_q.push_back(6'h02);
        PC          = 32'h020;
        resident[1] = 1;
        resident[2] = 2;
        seen        = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (!BUSYWAIT) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout("redirect_fill");
        check("redirect_instruction", {96'd0, INSTRUCTION}, {96'd0, words[8]});
        pause = 1'b0;
        present(32'h010, 1'b0);

        // Randomised fetch stream mixing sequential runs and jumps
        last_pc = 32'h010;
        for (int n = 0; n < 300; n++) begin
            mem_lat = $urandom_range(1, 4);
            if ($urandom_range(0, 2) != 0) pc = last_pc + 32'd4;
            else                           pc = $urandom;
            present(pc, 1'b0);
            last_pc = pc;
        end

        repeat (4) @(posedge CLK);
        check("pending_mem_requests", addr_q.size(), 128'd0);
        check("pending_fetches", exp_q.size(), 128'd0);
        finish_run();
    end

endmodule
